// File: rtl/adsr_voice_alloc_if.sv
// Note-event handshake bundle between the sequencer front end and the voice allocator.
interface adsr_voice_alloc_if #(
   parameter int NOTE_WIDTH = 7
) ();
   logic                  ev_valid;
   logic                  ev_ready;
   logic                  ev_on;
   logic [NOTE_WIDTH-1:0] ev_note;

   modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
   modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/adsr_voice_alloc.sv
// Polyphonic voice allocator: shares NUM_VOICES adsr generators between note events.
// Age-ranked allocation; a busy voice is retriggered through a low gap so the adsr
// edge detector always sees a fresh rising edge.
// Optional feature macro: ADSR_VOICE_STEAL_EN (steal the oldest held voice instead of
// dropping a note-on when every voice is held).

// Per-voice classification of the latched event against this voice's state.
module adsr_voice_slot #(
   parameter int NOTE_WIDTH = 7
) (
   input  logic                  trig,
   input  logic                  active,
   input  logic [NOTE_WIDTH-1:0] note,
   input  logic [NOTE_WIDTH-1:0] ev_note,
   output logic                  hit,
   output logic                  free,
   output logic                  rel
);
   assign hit  = trig & (note == ev_note);
   assign free = ~trig & ~active;
   assign rel  = ~trig & active;
endmodule

module adsr_voice_alloc #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_WIDTH = 7,
   parameter int RETRIG_GAP = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   adsr_voice_alloc_if.slave                ev,
   input  logic [NUM_VOICES-1:0]            env_active,
   output logic [NUM_VOICES-1:0]            trigger,
   output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
   output logic                             dropped
);
   localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int GW = (RETRIG_GAP > 1) ? $clog2(RETRIG_GAP) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_GAP    = 2'd2;

   typedef struct packed {
      logic                  on;
      logic [NOTE_WIDTH-1:0] note;
   } ev_t;

   logic [1:0]                            state_q, state_d;
   ev_t                                   ev_q, ev_d;
   logic [NUM_VOICES-1:0]                 trig_q, trig_d;
   logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] note_q, note_d;
   logic [NUM_VOICES-1:0][RW-1:0]         rank_q, rank_d;
   logic [GW-1:0]                         gap_q, gap_d;
   logic [RW-1:0]                         pend_q, pend_d;

   logic [NUM_VOICES-1:0] hit, free, rel;
   logic [RW-1:0]         hit_idx, free_idx, rel_idx, rel_rank;
   logic                  rel_found;
   logic                  asg, asg_busy;
   logic [RW-1:0]         asg_idx;
`ifdef ADSR_VOICE_STEAL_EN
   logic [RW-1:0]         old_idx, old_rank;
   logic                  old_found;
`else
   logic                  drop_q, drop_d;
`endif

   assign ev.ev_ready  = (state_q == S_IDLE);
   assign trigger      = trig_q;
   assign voice_note   = note_q;
`ifdef ADSR_VOICE_STEAL_EN
   assign dropped      = 1'b0;
`else
   assign dropped      = drop_q;
`endif

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
      adsr_voice_slot #(.NOTE_WIDTH(NOTE_WIDTH)) u_slot (
         .trig    (trig_q[v]),
         .active  (env_active[v]),
         .note    (note_q[v]),
         .ev_note (ev_q.note),
         .hit     (hit[v]),
         .free    (free[v]),
         .rel     (rel[v])
      );
   end

   // Candidate pickers: matching voice, lowest-index free voice, oldest released voice.
   always_comb begin
      hit_idx   = '0;
      free_idx  = '0;
      rel_idx   = '0;
      rel_rank  = '0;
      rel_found = 1'b0;
      for (int v = NUM_VOICES-1; v >= 0; v--) begin
         if (hit[v])  hit_idx  = RW'(v);
         if (free[v]) free_idx = RW'(v);
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (rel[v] && (!rel_found || rank_q[v] > rel_rank)) begin
            rel_found = 1'b1;
            rel_idx   = RW'(v);
            rel_rank  = rank_q[v];
         end
      end
   end

`ifdef ADSR_VOICE_STEAL_EN
   // Steal target: oldest voice whose trigger is still held.
   always_comb begin
      old_idx   = '0;
      old_rank  = '0;
      old_found = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (trig_q[v] && (!old_found || rank_q[v] > old_rank)) begin
            old_found = 1'b1;
            old_idx   = RW'(v);
            old_rank  = rank_q[v];
         end
      end
   end
`endif

   // Allocation FSM: accept, look up a voice, optionally hold trigger low through the gap.
   always_comb begin
      state_d  = state_q;
      ev_d     = ev_q;
      trig_d   = trig_q;
      note_d   = note_q;
      rank_d   = rank_q;
      gap_d    = gap_q;
      pend_d   = pend_q;
      asg      = 1'b0;
      asg_busy = 1'b0;
      asg_idx  = '0;
`ifndef ADSR_VOICE_STEAL_EN
      drop_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (ev.ev_valid) begin
               ev_d.on   = ev.ev_on;
               ev_d.note = ev.ev_note;
               state_d   = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            state_d = S_IDLE;
            if (!ev_q.on) begin
               // release: only a held voice playing this note is affected
               trig_d = trig_q & ~hit;
            end else if (|hit) begin
               asg      = 1'b1;
               asg_busy = 1'b1;
               asg_idx  = hit_idx;
            end else if (|free) begin
               asg     = 1'b1;
               asg_idx = free_idx;
            end else if (|rel) begin
               asg     = 1'b1;
               asg_idx = rel_idx;
`ifdef ADSR_VOICE_STEAL_EN
            end else begin
               asg      = 1'b1;
               asg_busy = 1'b1;
               asg_idx  = old_idx;
            end
`else
            end else begin
               drop_d = 1'b1;
            end
`endif
            if (asg) begin
               note_d[asg_idx] = ev_q.note;
               for (int u = 0; u < NUM_VOICES; u++) begin
                  if (rank_q[u] < rank_q[asg_idx]) rank_d[u] = rank_q[u] + RW'(1);
               end
               rank_d[asg_idx] = '0;
               if (asg_busy) begin
                  // held voice: drop trigger first so the generator sees a new edge
                  trig_d[asg_idx] = 1'b0;
                  pend_d          = asg_idx;
                  gap_d           = GW'(RETRIG_GAP - 1);
                  state_d         = S_GAP;
               end else begin
                  trig_d[asg_idx] = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               trig_d[pend_q] = 1'b1;
               state_d        = S_IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset returns every voice to free with ranks 0..NUM_VOICES-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ev_q    <= '0;
         trig_q  <= '0;
         note_q  <= '0;
         gap_q   <= '0;
         pend_q  <= '0;
         for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= RW'(v);
`ifndef ADSR_VOICE_STEAL_EN
         drop_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ev_q    <= ev_d;
         trig_q  <= trig_d;
         note_q  <= note_d;
         rank_q  <= rank_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
`ifndef ADSR_VOICE_STEAL_EN
         drop_q  <= drop_d;
`endif
      end
   end
endmodule

// File: tb/tb_adsr_voice_alloc.sv
// Scoreboard bench for adsr_voice_alloc: a transaction model predicts each event's outcome,
// the expectation is queued at drive time and compared cycle by cycle as the DUT responds.
// Honours ADSR_VOICE_STEAL_EN the same way as the design.
module tb_adsr_voice_alloc;
   localparam int NV = 4;
   localparam int NW = 7;
   localparam int RG = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NV-1:0]    env_active;
   logic [NV-1:0]    trigger;
   logic [NV*NW-1:0] voice_note;
   logic             dropped;

   adsr_voice_alloc_if #(.NOTE_WIDTH(NW)) ev_if ();

   adsr_voice_alloc #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .RETRIG_GAP(RG)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ev         (ev_if),
      .env_active (env_active),
      .trigger    (trigger),
      .voice_note (voice_note),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [NV-1:0]    trig1;
      logic [NV-1:0]    trig2;
      logic [NV*NW-1:0] notes;
      logic [2*NV-1:0]  ranks;
      logic             drop;
      logic             busy;
   } exp_t;

   exp_t sb_q[$];

   // Reference voice state
   logic [NV-1:0] m_trig;
   logic [NW-1:0] m_note [NV];
   int            m_rank [NV];

   task automatic model_reset();
      m_trig = '0;
      for (int v = 0; v < NV; v++) begin
         m_note[v] = '0;
         m_rank[v] = v;
      end
   endtask

   function automatic logic [2*NV-1:0] pack_ranks();
      logic [2*NV-1:0] r;
      for (int v = 0; v < NV; v++) r[v*2 +: 2] = 2'(m_rank[v]);
      return r;
   endfunction

   function automatic logic [NV*NW-1:0] pack_notes();
      logic [NV*NW-1:0] n;
      for (int v = 0; v < NV; v++) n[v*NW +: NW] = m_note[v];
      return n;
   endfunction

   task automatic predict(input logic on, input logic [NW-1:0] note, input logic [NV-1:0] env,
                          output exp_t e);
      int hit = -1;
      int sel = -1;
      int r0;
      e.drop  = 1'b0;
      e.busy  = 1'b0;
      e.trig1 = m_trig;
      for (int v = 0; v < NV; v++) if (m_trig[v] && m_note[v] == note) hit = v;
      if (!on) begin
         if (hit >= 0) m_trig[hit] = 1'b0;
      end else begin
         if (hit >= 0) begin
            sel = hit;
            e.busy = 1'b1;
         end
         if (sel < 0)
            for (int v = NV-1; v >= 0; v--) if (!m_trig[v] && !env[v]) sel = v;
         if (sel < 0)
            for (int v = 0; v < NV; v++)
               if (!m_trig[v] && env[v] && (sel < 0 || m_rank[v] > m_rank[sel])) sel = v;
`ifdef ADSR_VOICE_STEAL_EN
         if (sel < 0) begin
            for (int v = 0; v < NV; v++) if (m_rank[v] == NV-1) sel = v;
            e.busy = 1'b1;
         end
`else
         if (sel < 0) e.drop = 1'b1;
`endif
         if (sel >= 0) begin
            m_note[sel] = note;
            r0 = m_rank[sel];
            for (int v = 0; v < NV; v++) if (m_rank[v] < r0) m_rank[v]++;
            m_rank[sel] = 0;
            if (e.busy) begin
               m_trig[sel] = 1'b0;
               e.trig1 = m_trig;
            end
            m_trig[sel] = 1'b1;
         end
      end
      e.trig2 = m_trig;
      if (!e.busy) e.trig1 = m_trig;
      e.notes = pack_notes();
      e.ranks = pack_ranks();
   endtask

   // Drive one event with a decoy env_active outside LOOKUP, then check the response.
   task automatic send(input logic on, input logic [NW-1:0] note, input logic [NV-1:0] env,
                       input string tag);
      exp_t e;
      @(negedge clk);
      chk({tag, "/ready_idle"}, 32'(ev_if.ev_ready), 32'd1);
      predict(on, note, env, e);
      sb_q.push_back(e);
      ev_if.ev_valid = 1'b1;
      ev_if.ev_on    = on;
      ev_if.ev_note  = note;
      env_active     = ~env;
      @(posedge clk); #1;
      ev_if.ev_valid = 1'b0;
      env_active     = env;
      @(negedge clk);
      chk({tag, "/ready_lookup"}, 32'(ev_if.ev_ready), 32'd0);
      @(posedge clk); #1;
      env_active = ~env;
      @(negedge clk);
      e = sb_q.pop_front();
      chk({tag, "/trig_e1"}, 32'(trigger), 32'(e.trig1));
      chk({tag, "/dropped"}, 32'(dropped), 32'(e.drop));
      chk({tag, "/ready_e1"}, 32'(ev_if.ev_ready), 32'(!e.busy));
      chk({tag, "/notes"}, 32'(voice_note), 32'(e.notes));
      chk({tag, "/ranks"}, 32'(dut.rank_q), 32'(e.ranks));
      if (e.busy) begin
         for (int k = 1; k < RG; k++) begin
            @(negedge clk);
            chk({tag, "/trig_gap"}, 32'(trigger), 32'(e.trig1));
            chk({tag, "/ready_gap"}, 32'(ev_if.ev_ready), 32'd0);
         end
         @(negedge clk);
         chk({tag, "/trig_end"}, 32'(trigger), 32'(e.trig2));
         chk({tag, "/ready_end"}, 32'(ev_if.ev_ready), 32'd1);
      end else begin
         @(negedge clk);
         chk({tag, "/drop_clear"}, 32'(dropped), 32'd0);
         chk({tag, "/trig_end"}, 32'(trigger), 32'(e.trig2));
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst/trig", 32'(trigger), 32'd0);
      chk("rst/notes", 32'(voice_note), 32'd0);
      chk("rst/ranks", 32'(dut.rank_q), 32'hE4);
      chk("rst/dropped", 32'(dropped), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n        = 1'b0;
      env_active     = '0;
      ev_if.ev_valid = 1'b0;
      ev_if.ev_on    = 1'b0;
      ev_if.ev_note  = '0;
      model_reset();
      apply_reset();

      // fill all four voices, release one, retake it as the only released voice
      send(1'b1, 7'd60, 4'b0000, "on60");
      send(1'b1, 7'd62, 4'b0001, "on62");
      send(1'b1, 7'd64, 4'b0011, "on64");
      send(1'b1, 7'd65, 4'b0111, "on65");
      send(1'b0, 7'd62, 4'b1111, "off62");
      chk("off62/pattern", 32'(trigger), 32'b1101);
      send(1'b1, 7'd67, 4'b0010, "on67_rel");
      // every voice held: drop, or steal the oldest
      send(1'b1, 7'd70, 4'b1111, "on70_full");
      // same-note retrigger through the gap
      send(1'b1, 7'd64, 4'b1111, "on64_retrig");
      // note-off of a note never held
      send(1'b0, 7'd50, 4'b1111, "off50");
      // mixed random traffic over a small note range
      for (int i = 0; i < 24; i++)
         send(1'($urandom_range(0, 3) != 0), 7'(60 + $urandom_range(0, 5)),
              4'($urandom_range(0, 15)), "rand");

      // reset asserted in the middle of a retrigger gap
      apply_reset();
      send(1'b1, 7'd60, 4'b0000, "g_on60");
      send(1'b1, 7'd62, 4'b0000, "g_on62");
      @(negedge clk);
      ev_if.ev_valid = 1'b1;
      ev_if.ev_on    = 1'b1;
      ev_if.ev_note  = 7'd60;
      env_active     = 4'b0011;
      @(posedge clk); #1;
      ev_if.ev_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("gap/trig_low", 32'(trigger), 32'b0010);
      chk("gap/ready", 32'(ev_if.ev_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("gaprst/trig", 32'(trigger), 32'd0);
      chk("gaprst/ranks", 32'(dut.rank_q), 32'hE4);
      chk("gaprst/notes", 32'(voice_note), 32'd0);
      chk("gaprst/ready", 32'(ev_if.ev_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      send(1'b1, 7'd70, 4'b0000, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
